rom_upload_reader: RTL
======================

Name: rom_upload_reader

Overview:
- Read-back end of the ROM download path: serves HPS upload byte requests by reading the split 16-bit ROM (low/high byte lanes) and returning bytes in the original download byte order.
- Applies the exact inverse of the download address mapping, including the object-ROM bit shuffle above OBJADDR.
- Arbitrates for the shared ROM read port with the game and keeps a running 16-bit checksum of the bytes it returns.
- Sits beside the ROM download logic in the emu top, on clk_sys.

Parameters:
- OBJADDR, 106496, byte address where the object-ROM region starts.
- OBJLEN, 131072, object region length in bytes.
- RD_LAT, 1, ROM read latency in cycles from rom_addr valid to rom_data valid (range 1-3).

Ports:
- clk  in  1  system clock (clk_sys domain).
- rst  in  1  synchronous, active-high reset.
- ioctl_upload  in  1  level; high while an upload session is active.
- ioctl_rd  in  1  one-cycle byte request strobe.
- ioctl_addr  in  25  byte address of the request, sampled with ioctl_rd.
- ioctl_din  out  8  returned byte, held until the next valid.
- din_valid  out  1  one-cycle pulse; ioctl_din is new this cycle.
- busy  out  1  a request is in progress.
- rom_req  out  1  request for the shared ROM port.
- rom_gnt  in  1  port granted this cycle.
- rom_addr  out  17  word address to the ROM.
- rom_data  in  16  ROM word; [7:0] is the low lane, [15:8] the high lane.
- checksum  out  16  sum modulo 2^16 of all bytes returned this session.
- overrun  out  1  sticky; a request arrived while busy.

Behaviour:
- Reset values: ioctl_din=8'hFF, din_valid=0, busy=0, rom_req=0, rom_addr=0, checksum=0, overrun=0, FSM=IDLE.
- Session start: rising edge of ioctl_upload clears checksum and overrun in that cycle.
- Address decode (A = ioctl_addr, latched on acceptance):
  - A < OBJADDR: word=A[17:1]; lane=low if A[0]=1, else high.
  - OBJADDR <= A < OBJADDR+OBJLEN: o=A-OBJADDR (18-bit); word=OBJADDR[17:1]+{o[16:15],o[13:0]}, 17-bit wrap; lane=low if o[14]=1, else high.
  - A >= OBJADDR+OBJLEN, or A[24:18]!=0: out of range; no ROM access.
- IDLE:
  - ioctl_rd & ioctl_upload with an in-range address -> latch the decode, rom_req=1, busy=1 -> ARB.
  - Out-of-range address -> busy=1 for exactly one cycle, then din_valid=1 with ioctl_din=8'hFF -> IDLE.
  - ioctl_rd while ioctl_upload=0 is ignored.
- ARB: hold rom_req and rom_addr until rom_gnt=1. In the grant cycle, rom_addr stays stable, rom_req drops the next cycle, then start a latency counter at RD_LAT -> WAIT. A grant in the first ARB cycle is legal.
- WAIT: rom_addr held stable; count RD_LAT cycles after the grant cycle; capture the selected lane of rom_data -> DONE.
- DONE (one cycle):
  - din_valid=1; ioctl_din=captured byte.
  - checksum += {8'h00,byte}, wrapping.
  - busy=0 the next cycle -> IDLE.
  - Latency with grant in the first ARB cycle: the din_valid cycle is RD_LAT+2 cycles after ioctl_rd.
- ioctl_rd while busy=1: request dropped, overrun set (sticky until session start or reset); the current request completes normally.
- A new ioctl_rd in the same cycle as din_valid counts as busy and is dropped.
- ioctl_upload falling mid-request: abort to IDLE the next cycle, rom_req=0, no din_valid, checksum unchanged.
- Out-of-range bytes (8'hFF) are added to the checksum.
- rst mid-request: all outputs return to reset values the next cycle; no din_valid.

Test Plan:
- Upload session, ioctl_rd addr 0x00001, ROM word 0 = 16'hA55A, gnt tied high, RD_LAT=1 -> din_valid 3 cycles later, ioctl_din=8'h5A, checksum=16'h005A; addr 0x00000 -> 8'hA5, checksum=16'h00FF.
- Addr OBJADDR+0x4000 (o[14]=1), ROM word 53248 = 16'h1234 -> rom_addr=17'd53248, ioctl_din=8'h34; addr OBJADDR+0x8000 -> rom_addr=53248+16384=69632, high lane.
- rom_gnt held low 5 cycles -> rom_req and rom_addr stable for the whole wait, din_valid exactly RD_LAT+1 cycles after the grant cycle, single pulse.
- Addr 0x3A000 (beyond OBJADDR+OBJLEN) -> no rom_req, din_valid 2 cycles after the request, ioctl_din=8'hFF, checksum +0xFF.
- Second ioctl_rd one cycle after the first -> overrun=1, exactly one din_valid; re-raising ioctl_upload clears overrun and checksum to 0.
- ioctl_upload dropped in WAIT, and separately rst asserted in ARB -> no din_valid, busy=0 and rom_req=0 the next cycle; after rst, checksum=0 and ioctl_din=8'hFF.

Source files
------------

// File: rtl/rom_upload_reader.sv
// rom_upload_reader
// Read-back end of the ROM download path. Serves HPS upload byte requests
// by reading the split 16-bit ROM (low/high byte lanes) and returning each
// byte in the original download byte order. The address mapping is the
// exact inverse of the download mapping, including the object-ROM bit
// shuffle above OBJADDR. It arbitrates for the shared ROM read port and
// keeps a running 16-bit checksum of the returned bytes.
//
// Handshake semantics: rom_req is held high with a stable rom_addr until a
// cycle where rom_gnt=1 (the grant cycle); rom_req drops the cycle after.
// rom_data is valid RD_LAT cycles after the grant cycle. din_valid is a
// one-cycle pulse; ioctl_din holds its value until the next pulse. A request
// is only accepted while busy=0 and no din_valid pulse is present.
//
// Ports:
//   clk, rst          clk_sys and synchronous active-high reset
//   ioctl_upload      upload session active (level)
//   ioctl_rd          one-cycle byte request strobe, with ioctl_addr
//   ioctl_addr        25-bit byte address
//   ioctl_din         returned byte (8'hFF when out of range)
//   din_valid         one-cycle pulse, ioctl_din new this cycle
//   busy              a request is in progress
//   rom_req/rom_gnt   shared ROM port request / grant
//   rom_addr          17-bit ROM word address
//   rom_data          ROM word, [7:0] low lane, [15:8] high lane
//   checksum          sum mod 2^16 of bytes returned this session
//   overrun           sticky: a request arrived while busy
module rom_upload_reader #(
  parameter int OBJADDR = 106496,
  parameter int OBJLEN  = 131072,
  parameter int RD_LAT  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ioctl_upload,
  input  logic        ioctl_rd,
  input  logic [24:0] ioctl_addr,
  output logic [7:0]  ioctl_din,
  output logic        din_valid,
  output logic        busy,
  output logic        rom_req,
  input  logic        rom_gnt,
  output logic [16:0] rom_addr,
  input  logic [15:0] rom_data,
  output logic [15:0] checksum,
  output logic        overrun
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARB  = 3'd1,
    S_WAIT = 3'd2,
    S_DONE = 3'd3,
    S_OOR  = 3'd4
  } state_t;

  localparam logic [17:0] OBJ_LO = 18'(OBJADDR);
  localparam logic [18:0] OBJ_HI = 19'(OBJADDR + OBJLEN);

  state_t      r_state, w_state_n;
  logic [1:0]  r_cnt, w_cnt_n;
  logic        r_lane_lo, w_lane_lo_n;
  logic [16:0] r_rom_addr, w_rom_addr_n;
  logic        r_rom_req;
  logic        r_busy;
  logic        r_din_valid, w_din_valid_n;
  logic [7:0]  r_din, w_din_n;
  logic [15:0] r_checksum, w_checksum_n;
  logic        r_overrun, w_overrun_n;
  logic        r_upload_d;

  // Address decode of the incoming request
  logic        w_hi_zero;
  logic        w_in_low;
  logic        w_in_obj;
  logic [16:0] w_o;
  logic [16:0] w_obj_word;
  logic [16:0] w_dec_word;
  logic        w_dec_lane_lo;
  logic [7:0]  w_lane_byte;
  logic        w_req_seen;

  assign w_hi_zero  = (ioctl_addr[24:18] == 7'd0);
  assign w_in_low   = w_hi_zero && (ioctl_addr[17:0] < OBJ_LO);
  assign w_in_obj   = w_hi_zero && !w_in_low && ({1'b0, ioctl_addr[17:0]} < OBJ_HI);
  // Offset into the object region always fits in 17 bits when in range.
  assign w_o        = ioctl_addr[16:0] - OBJ_LO[16:0];
  // Bit 14 of the offset selects the lane; it is squeezed out of the word.
  assign w_obj_word = OBJ_LO[17:1] + {1'b0, w_o[16:15], w_o[13:0]};
  assign w_dec_word    = w_in_low ? ioctl_addr[17:1] : w_obj_word;
  assign w_dec_lane_lo = w_in_low ? ioctl_addr[0] : w_o[14];

  assign w_lane_byte = r_lane_lo ? rom_data[7:0] : rom_data[15:8];
  assign w_req_seen  = ioctl_rd && ioctl_upload;

  always_comb begin
    w_state_n     = r_state;
    w_cnt_n       = r_cnt;
    w_lane_lo_n   = r_lane_lo;
    w_rom_addr_n  = r_rom_addr;
    w_din_valid_n = 1'b0;
    w_din_n       = r_din;
    w_checksum_n  = r_checksum;
    w_overrun_n   = r_overrun;

    case (r_state)
      S_IDLE: begin
        // The din_valid cycle still counts as busy for new requests.
        if (w_req_seen && !r_din_valid) begin
          if (w_in_low || w_in_obj) begin
            w_rom_addr_n = w_dec_word;
            w_lane_lo_n  = w_dec_lane_lo;
            w_state_n    = S_ARB;
          end else begin
            w_state_n = S_OOR;
          end
        end
      end
      S_ARB: begin
        if (rom_gnt) begin
          w_cnt_n   = 2'(RD_LAT);
          w_state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == 2'd1) begin
          w_din_n       = w_lane_byte;
          w_din_valid_n = 1'b1;
          w_checksum_n  = r_checksum + {8'h00, w_lane_byte};
          w_state_n     = S_DONE;
        end else begin
          w_cnt_n = r_cnt - 2'd1;
        end
      end
      S_DONE: begin
        w_state_n = S_IDLE;
      end
      S_OOR: begin
        w_din_n       = 8'hFF;
        w_din_valid_n = 1'b1;
        w_checksum_n  = r_checksum + 16'h00FF;
        w_state_n     = S_IDLE;
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase

    if (w_req_seen && (r_busy || r_din_valid)) begin
      w_overrun_n = 1'b1;
    end

    // Session ended under an active request: abandon it silently.
    if (!ioctl_upload && (r_state != S_IDLE)) begin
      w_state_n     = S_IDLE;
      w_din_valid_n = 1'b0;
      w_din_n       = r_din;
      w_checksum_n  = r_checksum;
    end

    if (ioctl_upload && !r_upload_d) begin
      w_checksum_n = 16'h0000;
      w_overrun_n  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 2'd0;
      r_lane_lo   <= 1'b0;
      r_rom_addr  <= 17'd0;
      r_rom_req   <= 1'b0;
      r_busy      <= 1'b0;
      r_din_valid <= 1'b0;
      r_din       <= 8'hFF;
      r_checksum  <= 16'h0000;
      r_overrun   <= 1'b0;
      r_upload_d  <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_cnt       <= w_cnt_n;
      r_lane_lo   <= w_lane_lo_n;
      r_rom_addr  <= w_rom_addr_n;
      r_rom_req   <= (w_state_n == S_ARB);
      r_busy      <= (w_state_n != S_IDLE);
      r_din_valid <= w_din_valid_n;
      r_din       <= w_din_n;
      r_checksum  <= w_checksum_n;
      r_overrun   <= w_overrun_n;
      r_upload_d  <= ioctl_upload;
    end
  end

  assign ioctl_din = r_din;
  assign din_valid = r_din_valid;
  assign busy      = r_busy;
  assign rom_req   = r_rom_req;
  assign rom_addr  = r_rom_addr;
  assign checksum  = r_checksum;
  assign overrun   = r_overrun;

endmodule
